// File: rtl/ball_motion_if.sv
// rtl/ball_motion_if.sv - ball controller inputs, collision flags and position outputs
interface ball_motion_if;
    logic [10:0] vcounter;
    logic        req_right;
    logic        req_left;
    logic        req_up;
    logic        req_down;
    logic        restart;
    logic        stop_right;
    logic        stop_left;
    logic        stop_up;
    logic        stop_down;
    logic [10:0] x_ball;
    logic [10:0] y_ball;
    logic [4:0]  ball_width;
    logic        busy;
    logic        win;

    modport master (
        input  vcounter, req_right, req_left, req_up, req_down, restart,
        input  stop_right, stop_left, stop_up, stop_down,
        output x_ball, y_ball, ball_width, busy, win
    );

    modport slave (
        output vcounter, req_right, req_left, req_up, req_down, restart,
        output stop_right, stop_left, stop_up, stop_down,
        input  x_ball, y_ball, ball_width, busy, win
    );
endinterface

// File: rtl/ball_motion_ctrl.sv
// rtl/ball_motion_ctrl.sv - per-frame ball stepper with collision stops and goal detection
module ball_motion_ctrl #(
    parameter int START_X    = 20,
    parameter int START_Y    = 20,
    parameter int BALL_W     = 10,
    parameter int SPEED      = 2,
    parameter int FRAME_LINE = 481,
    parameter int X_MAX      = 639,
    parameter int Y_MAX      = 479,
    parameter int GOAL_X0    = 560,
    parameter int GOAL_Y0    = 440,
    parameter int GOAL_X1    = 610,
    parameter int GOAL_Y1    = 475
) (
    input  logic          clk,
    input  logic          rst_n,
    ball_motion_if.master bus_io
);
    typedef enum logic [2:0] {IDLE, MOVE_X, SETTLE_X, MOVE_Y, SETTLE_Y} state_t;

    // Bound checks run on 12 bits so x+BALL_W can never wrap.
    localparam logic [11:0] BW     = 12'(BALL_W);
    localparam logic [11:0] XMAX   = 12'(X_MAX);
    localparam logic [11:0] YMAX   = 12'(Y_MAX);
    localparam logic [11:0] GX0    = 12'(GOAL_X0);
    localparam logic [11:0] GY0    = 12'(GOAL_Y0);
    localparam logic [11:0] GX1    = 12'(GOAL_X1);
    localparam logic [11:0] GY1    = 12'(GOAL_Y1);
    localparam logic [3:0]  LAST   = 4'(SPEED - 1);
    localparam logic [10:0] SX     = 11'(START_X);
    localparam logic [10:0] SY     = 11'(START_Y);
    localparam logic [10:0] FLINE  = 11'(FRAME_LINE);

    state_t      state_q, state_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic [3:0]  step_q, step_d;
    logic        win_q, win_d;
    logic        line_seen_q, line_seen_d;

    logic        on_line;
    logic        tick;
    logic        go_right, go_left, go_up, go_down;
    logic [11:0] x_w, y_w;
    logic        in_goal;

    assign on_line  = (bus_io.vcounter == FLINE);
    assign tick     = on_line && !line_seen_q;
    assign go_right = bus_io.req_right && !bus_io.req_left;
    assign go_left  = bus_io.req_left  && !bus_io.req_right;
    assign go_down  = bus_io.req_down  && !bus_io.req_up;
    assign go_up    = bus_io.req_up    && !bus_io.req_down;
    assign x_w      = {1'b0, x_q};
    assign y_w      = {1'b0, y_q};
    assign in_goal  = (x_w >= GX0) && (x_w + BW <= GX1) &&
                      (y_w >= GY0) && (y_w + BW <= GY1);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        step_d      = step_q;
        win_d       = win_q;
        line_seen_d = on_line;
        if (bus_io.restart) begin
            state_d = IDLE;
            x_d     = SX;
            y_d     = SY;
            step_d  = 4'd0;
            win_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick && !win_q) begin
                        state_d = MOVE_X;
                        step_d  = 4'd0;
                    end
                end
                MOVE_X: begin
                    if (go_right && !bus_io.stop_right && (x_w + BW < XMAX)) begin
                        x_d = x_q + 11'd1;
                    end else if (go_left && !bus_io.stop_left && (x_q != 11'd0)) begin
                        x_d = x_q - 11'd1;
                    end
                    state_d = SETTLE_X;
                end
                SETTLE_X: state_d = MOVE_Y;
                MOVE_Y: begin
                    if (go_down && !bus_io.stop_down && (y_w + BW < YMAX)) begin
                        y_d = y_q + 11'd1;
                    end else if (go_up && !bus_io.stop_up && (y_q != 11'd0)) begin
                        y_d = y_q - 11'd1;
                    end
                    state_d = SETTLE_Y;
                end
                SETTLE_Y: begin
                    if (in_goal) begin
                        win_d   = 1'b1;
                        state_d = IDLE;
                    end else if (step_q == LAST) begin
                        state_d = IDLE;
                    end else begin
                        step_d  = step_q + 4'd1;
                        state_d = MOVE_X;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= SX;
            y_q         <= SY;
            step_q      <= 4'd0;
            win_q       <= 1'b0;
            line_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            step_q      <= step_d;
            win_q       <= win_d;
            line_seen_q <= line_seen_d;
        end
    end

    assign bus_io.x_ball     = x_q;
    assign bus_io.y_ball     = y_q;
    assign bus_io.ball_width = 5'(BALL_W);
    assign bus_io.busy       = (state_q != IDLE);
    assign bus_io.win        = win_q;
endmodule
